fir_sym_sequencer: RTL and testbench

Control FSM for the 317-tap symmetric FIR datapath. It accepts one input sample per valid/ready handshake and writes it into the circular sample memory. It then issues the half-filter sequence of read indices (k = 0 … filter_taps/2) and tracks the memory's fixed read latency with a tag pipeline. This lets it drive MAC clear/enable/center/last strobes aligned with the returning x_left/x_right pairs, and it pulses done when the final product has been presented.

---
 rtl/fir_sym_sequencer.sv | 95 +++++++++
 tb/tb_fir_sym_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/fir_sym_sequencer.sv
// fir_sym_sequencer: sample write, half-filter read issue and MAC strobe sequencing for a symmetric FIR
module fir_sym_sequencer #(
  parameter int data_width  = 16,
  parameter int filter_taps = 317,
  parameter int mem_latency = 7
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 s_valid,
  input  logic [data_width-1:0]                s_data,
  output logic                                 s_ready,
  output logic                                 mem_en_write,
  output logic [data_width-1:0]                mem_x_in,
  output logic                                 mem_en_read,
  output logic [$clog2(filter_taps/2)-1:0]     mem_k_index,
  output logic                                 mac_clear,
  output logic                                 mac_en,
  output logic                                 mac_center,
  output logic                                 mac_last,
  output logic                                 done,
  output logic                                 busy
);
  localparam int half = filter_taps / 2;
  localparam int kw = $clog2(half);
  localparam logic [kw-1:0] k_last = kw'(half);
  typedef enum logic [2:0] {IDLE, WRITE, ISSUE, DRAIN, DONE} state_t;
  state_t state;
  // tag = {valid, final pair}; the MAC strobe registers form the last stage of the latency match
  logic [1:0] tag [0:mem_latency-2];
  // Tag pipeline: follows each issued read so the MAC strobes line up with returning data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < mem_latency - 1; i++) tag[i] <= '0;
      mac_en     <= 1'b0;
      mac_center <= 1'b0;
      mac_last   <= 1'b0;
    end else begin
      tag[0] <= {mem_en_read, mem_en_read && mem_k_index == k_last};
      for (int i = 1; i < mem_latency - 1; i++) tag[i] <= tag[i-1];
      mac_en     <= tag[mem_latency-2][1];
      mac_center <= tag[mem_latency-2][0];
      mac_last   <= tag[mem_latency-2][0];
    end
  // Control FSM: handshake, single write, read issue, drain until the final pair, done pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      s_ready      <= 1'b0;
      mem_en_write <= 1'b0;
      mem_x_in     <= '0;
      mem_en_read  <= 1'b0;
      mem_k_index  <= '0;
      mac_clear    <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      mem_en_write <= 1'b0;
      mac_clear    <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          s_ready <= !(s_valid && s_ready);
          if (s_valid && s_ready) begin
            mem_x_in     <= s_data;
            mem_en_write <= 1'b1;
            mac_clear    <= 1'b1;
            busy         <= 1'b1;
            state        <= WRITE;
          end
        end
        WRITE: begin
          mem_en_read <= 1'b1;
          mem_k_index <= '0;
          state       <= ISSUE;
        end
        ISSUE:
          if (mem_k_index == k_last) begin
            mem_en_read <= 1'b0;
            state       <= DRAIN;
          end else
            mem_k_index <= mem_k_index + 1'b1;
        DRAIN:
          if (mac_en && mac_last) begin
            done  <= 1'b1;
            state <= DONE;
          end
        DONE: begin
          busy    <= 1'b0;
          s_ready <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fir_sym_sequencer.sv
// tb_fir_sym_sequencer: directed checks of handshake, read issue, MAC strobe timing, reset abort and stalls
module tb_fir_sym_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready, mem_en_write, mem_en_read, mac_clear, mac_en, mac_center, mac_last, done, busy;
  logic [15:0] mem_x_in;
  logic [7:0]  mem_k_index;
  int checks = 0;
  int failures = 0;
  int dcount = 0;
  fir_sym_sequencer dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_en_write(mem_en_write), .mem_x_in(mem_x_in), .mem_en_read(mem_en_read),
    .mem_k_index(mem_k_index), .mac_clear(mac_clear), .mac_en(mac_en), .mac_center(mac_center),
    .mac_last(mac_last), .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done) dcount++;
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  function automatic logic [63:0] all_outs();
    return 64'({s_ready, mem_en_write, mem_x_in, mem_en_read, mem_k_index, mac_clear, mac_en,
                mac_center, mac_last, done, busy});
  endfunction
  // Drives one sample in the current cycle (T0) and checks every cycle through T169
  task automatic run_sample(input logic [15:0] d, input bit keep);
    logic [8:0] ev;
    s_valid = 1'b1;
    s_data  = d;
    for (int t = 1; t <= 169; t++) begin
      @(posedge clk); #1;
      if (t == 1 && !keep) s_valid = 1'b0;
      if (t == 1) chk("x_in", 64'(mem_x_in), 64'(d));
      ev = {t == 1, t == 1, t >= 2 && t <= 160, t >= 9 && t <= 167, t == 167, t == 167,
            t == 168, t == 169, t <= 168};
      chk($sformatf("ctl_t%0d", t),
          64'({mem_en_write, mac_clear, mem_en_read, mac_en, mac_center, mac_last, done, s_ready, busy}),
          64'(ev));
      if (t >= 2) chk($sformatf("k_t%0d", t), 64'(mem_k_index), 64'(t <= 160 ? t - 2 : 158));
    end
  endtask
  initial begin
    logic [15:0] q[$];
    int bad, d0, writes, accepts;
    bit hs;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    repeat (5) @(posedge clk);
    #1 chk("rst_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", 64'({s_ready, busy}), 64'b10);
    run_sample(16'h4000, 1'b0);
    d0 = dcount;
    run_sample(16'h1111, 1'b1);
    run_sample(16'h8001, 1'b1);
    run_sample(16'hBEEF, 1'b1);
    s_valid = 1'b0;
    chk("b2b_dones", 64'(dcount - d0), 64'd3);
    s_valid = 1'b1;
    s_data = 16'h7FFF;
    for (int t = 1; t <= 50; t++) begin
      @(posedge clk); #1;
      if (t == 1) s_valid = 1'b0;
    end
    chk("t50_reading", 64'({mem_en_read, mem_k_index}), 64'({1'b1, 8'd48}));
    #2 rst_n = 1'b0;
    #1 chk("async_clr", all_outs(), 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("rst_hold", all_outs(), 64'd0);
    rst_n = 1'b1;
    bad = 0;
    d0 = dcount;
    repeat (200) begin
      @(posedge clk); #1;
      if (mac_en || done || mem_en_read || mem_en_write) bad++;
    end
    chk("abort_quiet", 64'(bad), 64'd0);
    chk("abort_nodone", 64'(dcount - d0), 64'd0);
    chk("abort_ready", 64'({s_ready, busy}), 64'b10);
    run_sample(16'h1234, 1'b0);
    hs = 1'b0;
    writes = 0;
    accepts = 0;
    for (int c = 0; c < 900; c++) begin
      @(posedge clk); #1;
      if (hs) begin
        s_valid = 1'b0;
        hs = 1'b0;
      end
      if (mem_en_write) begin
        writes++;
        chk($sformatf("stall_wr%0d", writes), 64'(mem_x_in), 64'(q.size() ? q.pop_front() : 16'hxxxx));
      end
      if (!s_valid && c < 650 && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b1;
        s_data = 16'($urandom);
      end
      if (s_valid && s_ready) begin
        q.push_back(s_data);
        accepts++;
        hs = 1'b1;
      end
    end
    chk("stall_count", 64'(writes), 64'(accepts));
    chk("stall_empty", 64'(q.size()), 64'd0);
    chk("stall_min", 64'(accepts >= 3), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
